vector_multiply: RTL and testbench
==================================

# vector_multiply

Four-lane element-wise unsigned multiplier: c_i = a_i × b_i for i = 1..4, computed in parallel. The result is registered and saturated to the output width. It is a datapath leaf used wherever two 4-element byte vectors are multiplied component-wise, for example ahead of an accumulator or dot-product stage. Input and output use a single valid-qualified transfer with no backpressure.

## Interface
- IN_W, default 8: width of each a_i / b_i operand, unsigned.
- OUT_W, default 9: width of each c_i result, unsigned; must satisfy IN_W+1 ≤ OUT_W ≤ 2·IN_W.
- SATURATE, default 1: 1 clamps results to 2^OUT_W−1; 0 keeps the low OUT_W bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a1..a4 / b1..b4 valid this cycle.
- a1, a2, a3, a4  in  IN_W  left operand vector, unsigned.
- b1, b2, b3, b4  in  IN_W  right operand vector, unsigned.
- out_valid  out  1  c1..c4 / ovf hold a new result.
- c1, c2, c3, c4  out  OUT_W  lane products after saturation or truncation.
- ovf  out  4  per-lane overflow flag; bit i−1 is set when the full product of lane i exceeds 2^OUT_W−1.

## Operation
- Each lane forms the full 2·IN_W-bit unsigned product p_i = a_i × b_i.
- Overflow: ovf[i−1] = (p_i > 2^OUT_W−1), independent of SATURATE.
- Result with SATURATE=1: c_i = ovf ? 2^OUT_W−1 : p_i[OUT_W−1:0].
- Result with SATURATE=0: c_i = p_i[OUT_W−1:0].
- Lanes are fully independent; there is no cross-lane carry or interaction.
- When in_valid=0, c1..c4 and ovf hold their last values and out_valid deasserts.
- There is no ready/backpressure: every valid input produces exactly one output beat.

## Timing
- Latency is 1 cycle. Operands are sampled at the rising edge where in_valid=1; c/ovf update at that edge, and out_valid=1 during the following cycle.
- Throughput is one vector per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- out_valid = registered in_valid.
- Reset (rst=1 at a rising edge):
  - c1..c4 = 0, ovf = 0, out_valid = 0.
  - rst takes priority over in_valid; an input presented in the reset cycle is dropped.
- Reset mid-stream: a result in flight is discarded. The first input accepted after rst deasserts produces out_valid one cycle later.
- Output widths are fixed by parameters; there are no X propagation paths from unused product bits.

## Structure
- Shared package vector_multiply_pkg holds:
  - IN_W / OUT_W defaults;
  - function sat_u(p, OUT_W) returning {ovf, clamped value};
  - localparam LANES = 4.
- Natural sub-module vm_lane (IN_W, OUT_W, SATURATE):
  - one multiplier plus saturate logic, combinational;
  - instantiated 4 times via generate.
- The top level owns all registers (c, ovf, out_valid).

## Test plan
- Nominal: a=(2,4,6,8), b=(3,5,7,9), in_valid pulse → next cycle c=(6,20,42,72), ovf=0000, out_valid=1 for one cycle.
- Saturation boundary, SATURATE=1: a=(22,16,255,0), b=(23,32,255,255) → c=(506,511,511,0), ovf=0110.
- Truncation, SATURATE=0, same stimulus → c=(506,0,1,0), ovf=0110 (65025 mod 512 = 1).
- Hold: one valid beat followed by 5 idle cycles → c stays at the first result, out_valid=1 only once; idle-cycle input changes do not alter c.
- Streaming: 4 consecutive valid vectors (k, k+1) for k=1..4 lanes-wide → out_valid high for 4 consecutive cycles with matching products in order.
- Reset mid-stream: rst asserted on a cycle with in_valid=1 → next cycle c=0, ovf=0, out_valid=0; the first post-reset input of 2×3 yields c1=6 one cycle later.

Source files
------------

// File: rtl/vector_multiply_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_multiply_pkg
// Description : Shared constants and the unsigned saturate helper for vector_multiply.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_multiply_pkg;

    localparam int IN_W_DEFAULT  = 8;
    localparam int OUT_W_DEFAULT = 9;
    localparam int LANES         = 4;

    // Returns {ovf, value}: value is the product clamped to 2^out_w-1, zero-extended
    // to 32 bits. Products wider than 32 bits are not supported.
    function automatic logic [32:0] sat_u(input logic [31:0] p, input int unsigned out_w);
        logic [32:0] lim;
        logic        ovf;
        lim = (33'd1 << out_w) - 33'd1;
        ovf = ({1'b0, p} > lim);
        return {ovf, (ovf ? lim[31:0] : p)};
    endfunction

endpackage : vector_multiply_pkg
`default_nettype wire

// File: rtl/vector_multiply_lane.sv
`default_nettype none
// ============================================================================
// Module      : vm_lane
// Description : One combinational lane: full unsigned product, overflow flag,
//               saturated or truncated result.
// Revision    : 1.0 - initial release
// ============================================================================
module vm_lane
    import vector_multiply_pkg::*;
#(
    parameter int IN_W     = IN_W_DEFAULT,
    parameter int OUT_W    = OUT_W_DEFAULT,
    parameter bit SATURATE = 1'b1
) (
    input  logic [IN_W-1:0]  i_a,
    input  logic [IN_W-1:0]  i_b,
    output logic [OUT_W-1:0] o_c,
    output logic             o_ovf
);

    logic [2*IN_W-1:0] w_prod;
    logic [32:0]       w_sat;
    logic              w_unused_sat;

    assign w_prod = i_a * i_b;
    assign w_sat  = sat_u(32'(w_prod), OUT_W);

    // Overflow is reported regardless of SATURATE; only the data path differs.
    assign o_ovf = w_sat[32];
    assign o_c   = SATURATE ? w_sat[OUT_W-1:0] : w_prod[OUT_W-1:0];

    assign w_unused_sat = ^w_sat[31:OUT_W];

endmodule : vm_lane
`default_nettype wire

// File: rtl/vector_multiply.sv
`default_nettype none
// ============================================================================
// Module      : vector_multiply
// Description : Four-lane element-wise unsigned multiplier with registered,
//               saturated (or truncated) outputs and 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_multiply
    import vector_multiply_pkg::*;
#(
    parameter int IN_W     = IN_W_DEFAULT,
    parameter int OUT_W    = OUT_W_DEFAULT,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a1,
    input  logic [IN_W-1:0]  a2,
    input  logic [IN_W-1:0]  a3,
    input  logic [IN_W-1:0]  a4,
    input  logic [IN_W-1:0]  b1,
    input  logic [IN_W-1:0]  b2,
    input  logic [IN_W-1:0]  b3,
    input  logic [IN_W-1:0]  b4,
    output logic             out_valid,
    output logic [OUT_W-1:0] c1,
    output logic [OUT_W-1:0] c2,
    output logic [OUT_W-1:0] c3,
    output logic [OUT_W-1:0] c4,
    output logic [3:0]       ovf
);

    logic [IN_W-1:0]  w_a [LANES];
    logic [IN_W-1:0]  w_b [LANES];
    logic [OUT_W-1:0] w_c [LANES];
    logic [LANES-1:0] w_ovf;

    logic [OUT_W-1:0] r_c [LANES];
    logic [LANES-1:0] r_ovf;
    logic             r_out_valid;

    assign w_a[0] = a1;
    assign w_a[1] = a2;
    assign w_a[2] = a3;
    assign w_a[3] = a4;
    assign w_b[0] = b1;
    assign w_b[1] = b2;
    assign w_b[2] = b3;
    assign w_b[3] = b4;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            vm_lane #(
                .IN_W     (IN_W),
                .OUT_W    (OUT_W),
                .SATURATE (SATURATE)
            ) u_lane (
                .i_a   (w_a[gi]),
                .i_b   (w_b[gi]),
                .o_c   (w_c[gi]),
                .o_ovf (w_ovf[gi])
            );
        end
    endgenerate

    // Results only load on valid beats so they hold through idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_c[i] <= '0;
            end
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_ovf <= w_ovf;
                for (int i = 0; i < LANES; i++) begin
                    r_c[i] <= w_c[i];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign c1        = r_c[0];
    assign c2        = r_c[1];
    assign c3        = r_c[2];
    assign c4        = r_c[3];

endmodule : vector_multiply
`default_nettype wire

// File: tb/tb_vector_multiply.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_multiply
// Description : Self-checking bench for vector_multiply, saturating and
//               truncating builds side by side against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_multiply;

    localparam int IN_W  = 8;
    localparam int OUT_W = 9;
    localparam int MAXV  = (1 << OUT_W) - 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] ta [4];
    logic [7:0] tb [4];

    logic       s_out_valid, t_out_valid;
    logic [8:0] s_c [4];
    logic [8:0] t_c [4];
    logic [3:0] s_ovf, t_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_sat [4];
    int   m_trn [4];
    logic [3:0] m_ovf;
    logic m_valid;

    vector_multiply #(.IN_W(IN_W), .OUT_W(OUT_W), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a1(ta[0]), .a2(ta[1]), .a3(ta[2]), .a4(ta[3]),
        .b1(tb[0]), .b2(tb[1]), .b3(tb[2]), .b4(tb[3]),
        .out_valid(s_out_valid),
        .c1(s_c[0]), .c2(s_c[1]), .c3(s_c[2]), .c4(s_c[3]),
        .ovf(s_ovf)
    );

    vector_multiply #(.IN_W(IN_W), .OUT_W(OUT_W), .SATURATE(1'b0)) u_dut_trn (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a1(ta[0]), .a2(ta[1]), .a3(ta[2]), .a4(ta[3]),
        .b1(tb[0]), .b2(tb[1]), .b3(tb[2]), .b4(tb[3]),
        .out_valid(t_out_valid),
        .c1(t_c[0]), .c2(t_c[1]), .c3(t_c[2]), .c4(t_c[3]),
        .ovf(t_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Applies one cycle of stimulus, advances the model, then checks both DUTs.
    task automatic step(input logic r, input logic v,
                        input int a0, input int a1v, input int a2v, input int a3v,
                        input int b0, input int b1v, input int b2v, input int b3v);
        int av [4];
        int bv [4];
        int p;
        av = '{a0, a1v, a2v, a3v};
        bv = '{b0, b1v, b2v, b3v};
        rst      = r;
        in_valid = v;
        for (int i = 0; i < 4; i++) begin
            ta[i] = av[i][7:0];
            tb[i] = bv[i][7:0];
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_ovf   = 4'b0;
            for (int i = 0; i < 4; i++) begin
                m_sat[i] = 0;
                m_trn[i] = 0;
            end
        end else begin
            m_valid = v;
            if (v) begin
                for (int i = 0; i < 4; i++) begin
                    p        = av[i] * bv[i];
                    m_ovf[i] = (p > MAXV);
                    m_sat[i] = (p > MAXV) ? MAXV : p;
                    m_trn[i] = p % (MAXV + 1);
                end
            end
        end
        #1;
        check("sat out_valid", 32'(s_out_valid), 32'(m_valid));
        check("trn out_valid", 32'(t_out_valid), 32'(m_valid));
        check("sat ovf", 32'(s_ovf), 32'(m_ovf));
        check("trn ovf", 32'(t_ovf), 32'(m_ovf));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sat c%0d", i + 1), 32'(s_c[i]), 32'(m_sat[i]));
            check($sformatf("trn c%0d", i + 1), 32'(t_c[i]), 32'(m_trn[i]));
        end
    endtask

    function automatic int rnd_op();
        // Bias towards small operands so both overflow and non-overflow lanes occur.
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 255));
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ta[i] = '0;
            tb[i] = '0;
        end

        // Reset state
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Nominal pulse, then idle
        step(1'b0, 1'b1, 2, 4, 6, 8, 3, 5, 7, 9);
        check("nominal c1", 32'(s_c[0]), 32'd6);
        check("nominal c4", 32'(s_c[3]), 32'd72);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Saturation / truncation boundary
        step(1'b0, 1'b1, 22, 16, 255, 0, 23, 32, 255, 255);
        check("boundary sat c3", 32'(s_c[2]), 32'd511);
        check("boundary trn c3", 32'(t_c[2]), 32'd1);
        check("boundary ovf", 32'(s_ovf), 32'b0110);

        // Hold: idle cycles with changing inputs must not disturb results
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                 rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end

        // Streaming back-to-back
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, k, k, k, k, k + 1, k + 1, k + 1, k + 1);
        end
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-stream drops the in-flight beat and the reset-cycle input
        step(1'b0, 1'b1, 200, 100, 50, 25, 200, 100, 50, 25);
        step(1'b1, 1'b1, 9, 9, 9, 9, 9, 9, 9, 9);
        step(1'b0, 1'b1, 2, 0, 0, 0, 3, 0, 0, 0);
        check("post-reset c1", 32'(s_c[0]), 32'd6);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                 rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vector_multiply
`default_nettype wire
